// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - free-running raster timing generator
//
// Purpose: generates pixel coordinates, sync pulses, active-draw flag,
// a one-cycle new-frame strobe and a frame counter on the pixel clock.
// All outputs are registered from the decode of the next counter values,
// so every flag describes the (hcount,vcount) presented in the same cycle.
//
// Ports:
//   i_pixel_clk    in   pixel clock
//   i_rst_n        in   asynchronous active-low reset
//   o_hcount       out  pixel column, 0..H_TOTAL-1
//   o_vcount       out  line, 0..V_TOTAL-1
//   o_hsync        out  horizontal sync, polarity SYNC_POL
//   o_vsync        out  vertical sync, polarity SYNC_POL
//   o_active_draw  out  high inside the visible area
//   o_nf           out  one-cycle strobe at (H_ACTIVE, V_ACTIVE)
//   o_frame_count  out  frames completed, modulo FRAME_WRAP
module video_timing_gen #(
  parameter int H_ACTIVE   = 1280,
  parameter int H_FP       = 110,
  parameter int H_SYNC     = 40,
  parameter int H_BP       = 220,
  parameter int V_ACTIVE   = 720,
  parameter int V_FP       = 5,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 20,
  parameter bit SYNC_POL   = 1'b1,
  parameter int FRAME_WRAP = 60
) (
  input  logic        i_pixel_clk,
  input  logic        i_rst_n,
  output logic [10:0] o_hcount,
  output logic [9:0]  o_vcount,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_active_draw,
  output logic        o_nf,
  output logic [5:0]  o_frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
  localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [5:0]  FC_LAST    = 6'(FRAME_WRAP - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [10:0] r_hcount;
  logic [9:0]  r_vcount;
  logic [10:0] w_hcount_nxt;
  logic [9:0]  w_vcount_nxt;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_active_draw;
  logic        r_nf;
  logic [5:0]  r_frame_count;
  logic        w_hsync_nxt;
  logic        w_vsync_nxt;
  logic        w_active_nxt;
  logic        w_nf_nxt;
  logic [5:0]  w_frame_count_nxt;

  // Next-state and next-counter logic. The IDLE->RUN edge holds (0,0) so the
  // first pixel after reset release is presented rather than skipped.
  always_comb begin
    w_state_nxt  = r_state;
    w_hcount_nxt = r_hcount;
    w_vcount_nxt = r_vcount;
    case (r_state)
      S_IDLE: begin
        w_state_nxt  = S_RUN;
        w_hcount_nxt = 11'd0;
        w_vcount_nxt = 10'd0;
      end
      S_RUN: begin
        if (r_hcount == H_LAST) begin
          w_hcount_nxt = 11'd0;
          w_vcount_nxt = (r_vcount == V_LAST) ? 10'd0 : r_vcount + 10'd1;
        end else begin
          w_hcount_nxt = r_hcount + 11'd1;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_hcount_nxt = 11'd0;
        w_vcount_nxt = 10'd0;
      end
    endcase
  end

  // Decode the next position so the registered flags line up with the
  // registered counters.
  always_comb begin
    w_hsync_nxt  = ((w_hcount_nxt >= HS_START) && (w_hcount_nxt <= HS_END)) ? SYNC_POL : ~SYNC_POL;
    w_vsync_nxt  = ((w_vcount_nxt >= VS_START) && (w_vcount_nxt <= VS_END)) ? SYNC_POL : ~SYNC_POL;
    w_active_nxt = (w_hcount_nxt < H_ACT) && (w_vcount_nxt < V_ACT);
    w_nf_nxt     = (w_hcount_nxt == H_ACT) && (w_vcount_nxt == V_ACT);
    // Counter steps on the edge after the strobe cycle.
    w_frame_count_nxt = r_frame_count;
    if (r_nf) begin
      w_frame_count_nxt = (r_frame_count == FC_LAST) ? 6'd0 : r_frame_count + 6'd1;
    end
  end

  always_ff @(posedge i_pixel_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_hcount      <= 11'd0;
      r_vcount      <= 10'd0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_active_draw <= 1'b0;
      r_nf          <= 1'b0;
      r_frame_count <= 6'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_hcount      <= w_hcount_nxt;
      r_vcount      <= w_vcount_nxt;
      r_hsync       <= w_hsync_nxt;
      r_vsync       <= w_vsync_nxt;
      r_active_draw <= w_active_nxt;
      r_nf          <= w_nf_nxt;
      r_frame_count <= w_frame_count_nxt;
    end
  end

  assign o_hcount      = r_hcount;
  assign o_vcount      = r_vcount;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_active_draw = r_active_draw;
  assign o_nf          = r_nf;
  assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - self-checking bench for video_timing_gen
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a_n;
  logic        rst_b_n;
  logic [10:0] a_h, b_h;
  logic [9:0]  a_v, b_v;
  logic        a_hs, a_vs, a_ad, a_nf;
  logic        b_hs, b_vs, b_ad, b_nf;
  logic [5:0]  a_fc, b_fc;

  int checks   = 0;
  int failures = 0;

  // Default 1280x720 instance.
  video_timing_gen u_dut (
    .i_pixel_clk   (clk),
    .i_rst_n       (rst_a_n),
    .o_hcount      (a_h),
    .o_vcount      (a_v),
    .o_hsync       (a_hs),
    .o_vsync       (a_vs),
    .o_active_draw (a_ad),
    .o_nf          (a_nf),
    .o_frame_count (a_fc)
  );

  // Small inverted-polarity instance: H 8/2/2/2, V 4/1/1/1.
  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .FRAME_WRAP(60)
  ) u_small (
    .i_pixel_clk   (clk),
    .i_rst_n       (rst_b_n),
    .o_hcount      (b_h),
    .o_vcount      (b_v),
    .o_hsync       (b_hs),
    .o_vsync       (b_vs),
    .o_active_draw (b_ad),
    .o_nf          (b_nf),
    .o_frame_count (b_fc)
  );

  logic [30:0] obs_a, obs_b;
  assign obs_a = {a_h, a_v, a_hs, a_vs, a_ad, a_nf, a_fc};
  assign obs_b = {b_h, b_v, b_hs, b_vs, b_ad, b_nf, b_fc};

  localparam logic [30:0] RST_A = {11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
  localparam logic [30:0] RST_B = {11'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0};

  // Expected outputs t cycles after the first post-release edge, from the
  // raster arithmetic: position = t mod frame, frames completed = number of
  // strobe positions strictly before t.
  function automatic logic [30:0] model(input int t, input int ha, input int hfp,
      input int hsw, input int hbp, input int va, input int vfp, input int vsw,
      input int vbp, input bit pol, input int wrap);
    int ht, vt, ft, p, h, v, n0, nfc;
    logic hsy, vsy, ad, nf;
    ht  = ha + hfp + hsw + hbp;
    vt  = va + vfp + vsw + vbp;
    ft  = ht * vt;
    p   = t % ft;
    h   = p % ht;
    v   = p / ht;
    hsy = (h >= ha + hfp && h < ha + hfp + hsw) ? pol : !pol;
    vsy = (v >= va + vfp && v < va + vfp + vsw) ? pol : !pol;
    ad  = (h < ha) && (v < va);
    nf  = (h == ha) && (v == va);
    n0  = va * ht + ha;
    nfc = (t - 1 >= n0) ? ((t - 1 - n0) / ft + 1) : 0;
    return {11'(h), 10'(v), hsy, vsy, ad, nf, 6'(nfc % wrap)};
  endfunction

  function automatic logic [30:0] model_a(input int t);
    return model(t, 1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 60);
  endfunction

  function automatic logic [30:0] model_b(input int t);
    return model(t, 8, 2, 2, 2, 4, 1, 1, 1, 1'b0, 60);
  endfunction

  task automatic reset_a(input int n);
    rst_a_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_a_n = 1'b1;
  endtask

  task automatic reset_b(input int n);
    rst_b_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_b_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (obs_a !== RST_A) begin
      failures++;
      $display("FAIL reset_a got=%h exp=%h", obs_a, RST_A);
    end
    checks++;
    if (obs_b !== RST_B) begin
      failures++;
      $display("FAIL reset_b got=%h exp=%h", obs_b, RST_B);
    end
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_h, a_v, a_ad, a_nf} !== {11'd0, 10'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL first_edge got h=%0d v=%0d ad=%b nf=%b exp h=0 v=0 ad=1 nf=0", a_h, a_v, a_ad, a_nf);
    end
    @(negedge clk);
    checks++;
    if (a_h !== 11'd1 || a_v !== 10'd0) begin
      failures++;
      $display("FAIL second_edge got h=%0d v=%0d exp h=1 v=0", a_h, a_v);
    end
  endtask

  task automatic test_line_timing();
    int n_ad, n_hs, hs_first, hs_last;
    logic [30:0] exp;
    n_ad = 0; n_hs = 0; hs_first = -1; hs_last = -1;
    reset_a($urandom_range(1, 5));
    for (int t = 0; t < 2 * 1650 + 10; t++) begin
      @(negedge clk);
      exp = model_a(t);
      checks++;
      if (obs_a !== exp) begin
        failures++;
        $display("FAIL line_a t=%0d got=%h exp=%h", t, obs_a, exp);
      end
      if (t < 1650) begin
        if (a_ad === 1'b1) n_ad++;
        if (a_hs === 1'b1) begin
          n_hs++;
          if (hs_first < 0) hs_first = t;
          hs_last = t;
        end
      end
      if (t == 1650) begin
        checks++;
        if (a_h !== 11'd0 || a_v !== 10'd1) begin
          failures++;
          $display("FAIL line_wrap got h=%0d v=%0d exp h=0 v=1", a_h, a_v);
        end
      end
    end
    checks++;
    if (n_ad != 1280) begin
      failures++;
      $display("FAIL active_count got=%0d exp=1280", n_ad);
    end
    checks++;
    if (n_hs != 40 || hs_first != 1390 || hs_last != 1429) begin
      failures++;
      $display("FAIL hsync_window got n=%0d first=%0d last=%0d exp n=40 first=1390 last=1429", n_hs, hs_first, hs_last);
    end
  endtask

  task automatic test_frame_count();
    int n_nf, n_hs0, n_vs0;
    logic prev_nf;
    logic [5:0] prev_fc;
    logic [30:0] exp;
    n_nf = 0; n_hs0 = 0; n_vs0 = 0; prev_nf = 1'b0; prev_fc = 6'd0;
    reset_b($urandom_range(1, 5));
    for (int t = 0; t < 61 * 98; t++) begin
      @(negedge clk);
      exp = model_b(t);
      checks++;
      if (obs_b !== exp) begin
        failures++;
        $display("FAIL frame_b t=%0d got=%h exp=%h", t, obs_b, exp);
      end
      if (b_nf === 1'b1) n_nf++;
      if (t < 98) begin
        if (b_hs === 1'b0) n_hs0++;
        if (b_vs === 1'b0) n_vs0++;
      end
      if (prev_nf === 1'b1) begin
        checks++;
        if (b_fc !== ((prev_fc == 6'd59) ? 6'd0 : prev_fc + 6'd1)) begin
          failures++;
          $display("FAIL fc_step t=%0d got=%0d prev=%0d", t, b_fc, prev_fc);
        end
      end
      if (t == 97 || t == 98) begin
        checks++;
        if ({b_h, b_v} !== ((t == 97) ? {11'd13, 10'd6} : {11'd0, 10'd0})) begin
          failures++;
          $display("FAIL frame_wrap t=%0d got h=%0d v=%0d", t, b_h, b_v);
        end
      end
      prev_nf = b_nf;
      prev_fc = b_fc;
    end
    checks++;
    if (n_nf != 61 || b_fc !== 6'd1) begin
      failures++;
      $display("FAIL nf_total got nf=%0d fc=%0d exp nf=61 fc=1", n_nf, b_fc);
    end
    checks++;
    if (n_hs0 != 14 || n_vs0 != 14) begin
      failures++;
      $display("FAIL polarity got hs_low=%0d vs_low=%0d exp 14 14", n_hs0, n_vs0);
    end
  endtask

  task automatic test_midframe_reset();
    logic [30:0] exp;
    int k;
    for (int it = 0; it < 4; it++) begin
      reset_b($urandom_range(1, 3));
      k = $urandom_range(5, 400);
      for (int t = 0; t < k; t++) begin
        @(negedge clk);
        exp = model_b(t);
        checks++;
        if (obs_b !== exp) begin
          failures++;
          $display("FAIL pre_rst_b t=%0d got=%h exp=%h", t, obs_b, exp);
        end
      end
      #2 rst_b_n = 1'b0;
      #1;
      checks++;
      if (obs_b !== RST_B) begin
        failures++;
        $display("FAIL async_rst_b got=%h exp=%h", obs_b, RST_B);
      end
      repeat ($urandom_range(1, 4)) @(negedge clk);
      rst_b_n = 1'b1;
      for (int t = 0; t < 200; t++) begin
        @(negedge clk);
        exp = model_b(t);
        checks++;
        if (obs_b !== exp) begin
          failures++;
          $display("FAIL post_rst_b t=%0d got=%h exp=%h", t, obs_b, exp);
        end
      end
    end
    reset_a(2);
    k = $urandom_range(600, 1700);
    for (int t = 0; t < k; t++) @(negedge clk);
    #2 rst_a_n = 1'b0;
    #1;
    checks++;
    if (obs_a !== RST_A) begin
      failures++;
      $display("FAIL async_rst_a got=%h exp=%h", obs_a, RST_A);
    end
    repeat (2) @(negedge clk);
    rst_a_n = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      exp = model_a(t);
      checks++;
      if (obs_a !== exp) begin
        failures++;
        $display("FAIL post_rst_a t=%0d got=%h exp=%h", t, obs_a, exp);
      end
    end
  endtask

  initial begin
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    test_reset();
    test_line_timing();
    test_frame_count();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
